seq_hit_monitor: RTL and testbench
==================================

Name: seq_hit_monitor

Overview:
- Downstream consumer of the single-bit Moore detector output (the 1010 overlapping sequence detector `out`).
- Counts detection pulses in fixed-length observation windows and reports the count of each completed window.
- Raises a sticky alarm when a window's count reaches a programmable threshold, and keeps a saturating lifetime hit total.
- Feeds the status/interrupt logic with `alarm` and `last_count`.

Parameters:
- CNT_W, 8: width of the per-window hit count and the threshold.
- TOTAL_W, 16: width of the lifetime saturating hit counter.
- WIN_W, 8: width of the window cycle timer.
- WINDOW, 100: window length in clock cycles. Legal range is 2 to 2^WIN_W-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset. rst=0 clears all state immediately.
- en  in  1  monitor enable; level-sensitive.
- hit  in  1  detector output. Each cycle with hit=1 is one event; back-to-back highs count separately.
- thresh  in  CNT_W  alarm threshold. 0 disables the alarm.
- alarm_ack  in  1  clears the alarm (level, sampled each cycle).
- last_count  out  CNT_W  hit count of the most recently completed window.
- total_count  out  TOTAL_W  saturating count of all hits accepted while not IDLE.
- win_done  out  1  one-cycle pulse marking completion of a window.
- alarm  out  1  sticky threshold alarm.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; internal win_cnt=0 and win_tmr=0; all outputs=0.
- All outputs are registered. No combinational input-to-output path.
- States are IDLE, WINDOW and ALARM.
- IDLE:
  - hit is ignored. Counters hold.
  - en=1 → WINDOW with win_tmr=0 and win_cnt=0.
  - A hit in the same cycle en is first seen in IDLE is not counted.
- WINDOW, each edge:
  - hit=1 → win_cnt+1, saturating at 2^CNT_W-1, and total_count+1, saturating at 2^TOTAL_W-1.
  - win_tmr+1 each edge.
  - en=0 → IDLE at that edge (abort). Hits in that cycle are discarded. No win_done. last_count is unchanged.
- Window end (win_tmr==WINDOW-1 and en=1):
  - final = win_cnt + hit (saturated).
  - last_count ← final, and win_done=1 for exactly one cycle.
  - If thresh!=0 and final>=thresh → ALARM, alarm←1.
  - Otherwise a new window starts back-to-back: win_tmr=0 and win_cnt=0. There is no dead cycle between windows.
- ALARM:
  - alarm holds at 1. Hits increment total_count only.
  - alarm_ack=1 → alarm←0 at that edge. Then en=1 → WINDOW (fresh window); en=0 → IDLE.
  - en=0 without ack → stay in ALARM. The alarm is not lost.
- thresh is sampled only at window end, so changes mid-window are allowed.
- alarm_ack outside ALARM has no effect.
- Reset mid-window or mid-alarm: everything clears, including alarm and last_count.
- busy = (state != IDLE).

Optional Feature:
- Macro: SEQ_HIT_GAP_MEASURE_EN.
- Defined:
  - Adds output min_gap [WIN_W-1:0]. Reset value is all-ones.
  - A gap counter runs while not IDLE: it resets to 0 on each accepted hit and saturates otherwise.
  - On each accepted hit after the first since reset, if gap+1 < min_gap then min_gap ← gap+1. Example: hits on consecutive cycles give min_gap=1; overlapping 1010 detections give 2.
  - Entering IDLE invalidates the "previous hit" flag. min_gap persists until reset.
- Not defined: the port and logic are absent. All other behaviour is identical.

Test Plan:
- WINDOW=16, thresh=3. Reset low 3 cycles, then en=1; hits at window cycles 2, 4 and 9 → at cycle 15 win_done=1 (one cycle), last_count=3, alarm=1, busy=1. alarm_ack pulse → alarm=0 next edge, new window starts.
- thresh=5; 2 hits per window for 3 windows → win_done every 16 cycles, last_count=2 each time, alarm stays 0, total_count=6.
- Hit asserted only in the final window cycle (win_tmr=15), thresh=1 → last_count=1, alarm=1.
- en dropped at window cycle 7 after 4 hits → IDLE next edge, win_done never pulses, last_count keeps its prior value, total_count=4, busy=0.
- CNT_W=8; hit held high 300 cycles in WINDOW=256+ config (WIN_W=9, WINDOW=300), thresh=0 → last_count=255 (saturated), alarm=0. total_count=300.
- With SEQ_HIT_GAP_MEASURE_EN: stream 1010 10 10 into the upstream detector → hits 2 cycles apart, min_gap=2. Assert rst=0 mid-window → all outputs 0 and min_gap all-ones immediately.

Source files
------------

// File: rtl/seq_hit_monitor.sv
// seq_hit_monitor: windowed hit counter with sticky threshold alarm and saturating lifetime total.
// Optional min-gap measurement is enabled by defining SEQ_HIT_GAP_MEASURE_EN.
module seq_hit_monitor #(
    parameter int CNT_W   = 8,
    parameter int TOTAL_W = 16,
    parameter int WIN_W   = 8,
    parameter int WINDOW  = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               hit,
    input  logic [CNT_W-1:0]   thresh,
    input  logic               alarm_ack,
    output logic [CNT_W-1:0]   last_count,
    output logic [TOTAL_W-1:0] total_count,
    output logic               win_done,
    output logic               alarm,
    output logic               busy
`ifdef SEQ_HIT_GAP_MEASURE_EN
    ,
    output logic [WIN_W-1:0]   min_gap
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_WINDOW, S_ALARM} state_t;

    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
    localparam logic [TOTAL_W-1:0] TOT_MAX = {TOTAL_W{1'b1}};
    localparam logic [WIN_W-1:0]   LAST    = WIN_W'(WINDOW - 1);

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_win_cnt, w_win_cnt;
    logic [WIN_W-1:0]   r_win_tmr, w_win_tmr;
    logic [CNT_W-1:0]   w_final, w_last;
    logic [TOTAL_W-1:0] w_total;
    logic               w_in_win, w_end, w_trip, w_acc;

    assign w_in_win = (r_state == S_WINDOW) && en;
    assign w_end    = w_in_win && (r_win_tmr == LAST);
    assign w_final  = (hit && r_win_cnt != CNT_MAX) ? r_win_cnt + 1'b1 : r_win_cnt;
    assign w_trip   = (thresh != '0) && (w_final >= thresh);
    assign w_acc    = hit && (w_in_win || r_state == S_ALARM);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state: abort on en low in a window, alarm only leaves on ack
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = en ? S_WINDOW : S_IDLE;
            S_WINDOW: w_next = !en ? S_IDLE : (w_end && w_trip) ? S_ALARM : S_WINDOW;
            S_ALARM:  w_next = !alarm_ack ? S_ALARM : en ? S_WINDOW : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Next values of the window counters and registered outputs; any window entry or end restarts the counters
    always_comb begin
        w_win_tmr = (w_in_win && !w_end) ? r_win_tmr + 1'b1 :
                    (w_end || w_next == S_WINDOW) ? '0 : r_win_tmr;
        w_win_cnt = (w_in_win && !w_end) ? w_final :
                    (w_end || w_next == S_WINDOW) ? '0 : r_win_cnt;
        w_last    = w_end ? w_final : last_count;
        w_total   = (w_acc && total_count != TOT_MAX) ? total_count + 1'b1 : total_count;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win_cnt   <= '0;
            r_win_tmr   <= '0;
            last_count  <= '0;
            total_count <= '0;
            win_done    <= 1'b0;
            alarm       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_win_cnt   <= w_win_cnt;
            r_win_tmr   <= w_win_tmr;
            last_count  <= w_last;
            total_count <= w_total;
            win_done    <= w_end;
            alarm       <= (w_next == S_ALARM);
            busy        <= (w_next != S_IDLE);
        end
    end

`ifdef SEQ_HIT_GAP_MEASURE_EN
    logic [WIN_W-1:0] r_gap;
    logic             r_prev;
    logic [WIN_W:0]   w_gap_inc;

    assign w_gap_inc = {1'b0, r_gap} + 1'b1;

    // Shortest spacing between accepted hits; the previous-hit flag is dropped whenever IDLE is entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gap   <= '0;
            r_prev  <= 1'b0;
            min_gap <= '1;
        end else begin
            if (w_acc) begin
                if (r_prev && w_gap_inc < {1'b0, min_gap}) min_gap <= w_gap_inc[WIN_W-1:0];
                r_gap  <= '0;
                r_prev <= 1'b1;
            end else if (r_state != S_IDLE && r_gap != '1) begin
                r_gap <= r_gap + 1'b1;
            end
            if (w_next == S_IDLE) r_prev <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_seq_hit_monitor.sv
// tb_seq_hit_monitor: directed test of seq_hit_monitor (16-cycle window and 300-cycle saturation instance)
module tb_seq_hit_monitor;
    logic        clk = 1'b0;
    logic        rst;
    logic        en, hit, alarm_ack;
    logic [7:0]  thresh;
    logic [7:0]  last_count;
    logic [15:0] total_count;
    logic        win_done, alarm, busy;
    logic        en_b, hit_b;
    logic [7:0]  last_b;
    logic [15:0] total_b;
    logic        wd_b, alarm_b, busy_b;
`ifdef SEQ_HIT_GAP_MEASURE_EN
    logic [7:0]  min_gap;
    logic [8:0]  min_gap_b;
`endif
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_hit_monitor #(.CNT_W(8), .TOTAL_W(16), .WIN_W(8), .WINDOW(16)) dut (
        .clk(clk), .rst(rst), .en(en), .hit(hit), .thresh(thresh), .alarm_ack(alarm_ack),
        .last_count(last_count), .total_count(total_count), .win_done(win_done),
        .alarm(alarm), .busy(busy)
`ifdef SEQ_HIT_GAP_MEASURE_EN
        , .min_gap(min_gap)
`endif
    );

    seq_hit_monitor #(.CNT_W(8), .TOTAL_W(16), .WIN_W(9), .WINDOW(300)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .hit(hit_b), .thresh(8'd0), .alarm_ack(1'b0),
        .last_count(last_b), .total_count(total_b), .win_done(wd_b),
        .alarm(alarm_b), .busy(busy_b)
`ifdef SEQ_HIT_GAP_MEASURE_EN
        , .min_gap(min_gap_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; hit = 1'b0; alarm_ack = 1'b0; thresh = 8'd3;
        en_b = 1'b0; hit_b = 1'b0;
        repeat (3) tick();
        check("rst_last", last_count, 0);
        check("rst_total", total_count, 0);
        check("rst_wd", win_done, 0);
        check("rst_alarm", alarm, 0);
        check("rst_busy", busy, 0);
`ifdef SEQ_HIT_GAP_MEASURE_EN
        check("rst_min_gap", min_gap, 8'hFF);
`endif
        rst = 1'b1;
        tick();
        // window with hits at cycles 2, 4, 9 and threshold 3
        en = 1'b1;
        tick();
        check("busy_on", busy, 1);
        for (int k = 0; k < 16; k++) begin
            hit = (k == 2 || k == 4 || k == 9);
            tick();
            if (k == 14) check("wd_early", win_done, 0);
        end
        hit = 1'b0;
        check("w1_wd", win_done, 1);
        check("w1_last", last_count, 3);
        check("w1_alarm", alarm, 1);
        check("w1_busy", busy, 1);
        check("w1_total", total_count, 3);
`ifdef SEQ_HIT_GAP_MEASURE_EN
        check("w1_min_gap", min_gap, 2);
`endif
        tick();
        check("wd_one_cycle", win_done, 0);
        check("alarm_hold", alarm, 1);
        alarm_ack = 1'b1;
        thresh = 8'd5;
        tick();
        alarm_ack = 1'b0;
        check("ack_alarm", alarm, 0);
        check("ack_busy", busy, 1);
        // three windows, two hits each, below threshold
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 16; k++) begin
                hit = (k == 1 || k == 10);
                tick();
                if (k == 7) check("w2_wd_mid", win_done, 0);
            end
            hit = 1'b0;
            check("w2_wd", win_done, 1);
            check("w2_last", last_count, 2);
            check("w2_alarm", alarm, 0);
        end
        check("w2_total", total_count, 9);
        // single hit in the final window cycle, threshold 1
        thresh = 8'd1;
        for (int k = 0; k < 16; k++) begin
            hit = (k == 15);
            tick();
        end
        hit = 1'b0;
        check("w3_last", last_count, 1);
        check("w3_alarm", alarm, 1);
        check("w3_total", total_count, 10);
        en = 1'b0;
        tick();
        check("alarm_en0_hold", alarm, 1);
        check("alarm_en0_busy", busy, 1);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("alarm_hit_total", total_count, 11);
        alarm_ack = 1'b1;
        tick();
        alarm_ack = 1'b0;
        check("ack_idle_alarm", alarm, 0);
        check("ack_idle_busy", busy, 0);
        // hit on the enabling cycle is ignored; abort at window cycle 7
        en = 1'b1; hit = 1'b1;
        tick();
        check("start_hit_ignored", total_count, 11);
        for (int k = 0; k < 7; k++) begin
            hit = (k == 0 || k == 2 || k == 4 || k == 5);
            tick();
        end
        en = 1'b0; hit = 1'b1;
        tick();
        hit = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_total", total_count, 15);
        check("abort_last", last_count, 1);
        check("abort_wd", win_done, 0);
`ifdef SEQ_HIT_GAP_MEASURE_EN
        check("abort_min_gap", min_gap, 1);
`endif
        hit = 1'b1;
        repeat (3) tick();
        hit = 1'b0;
        check("idle_hit_ignored", total_count, 15);
        // saturation: 300 consecutive hits in a 300-cycle window, threshold 0
        en_b = 1'b1;
        tick();
        hit_b = 1'b1;
        repeat (300) tick();
        check("sat_wd", wd_b, 1);
        check("sat_last", last_b, 255);
        check("sat_alarm", alarm_b, 0);
        check("sat_total", total_b, 300);
`ifdef SEQ_HIT_GAP_MEASURE_EN
        check("sat_min_gap", min_gap_b, 1);
`endif
        hit_b = 1'b0; en_b = 1'b0;
        tick();
        check("sat_busy", busy_b, 0);
        // asynchronous reset in the middle of a window
        en = 1'b1;
        tick();
        hit = 1'b1;
        repeat (2) tick();
        hit = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_last", last_count, 0);
        check("arst_total", total_count, 0);
        check("arst_busy", busy, 0);
        check("arst_alarm", alarm, 0);
        check("arst_wd", win_done, 0);
        check("arst_b_last", last_b, 0);
        check("arst_b_total", total_b, 0);
`ifdef SEQ_HIT_GAP_MEASURE_EN
        check("arst_min_gap", min_gap, 8'hFF);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
